fp_mul_pipe: RTL
================

# fp_mul_pipe

- Parametrised, pipelined IEEE-754-style floating-point multiplier with a valid/ready stream interface on input and output.
- Generalises the team's fixed 16-bit combinational FP multiplier to any exponent/mantissa width, adds a 3-stage pipeline with backpressure, NaN/Inf handling and round-to-nearest-even.
- Sits between operand-fetch logic and result writeback in the FP datapath.

## Interface
- EXP_W, 5, exponent field width (≥3); bias = 2^(EXP_W-1)-1
- MAN_W, 10, stored mantissa field width (≥2); word width W = 1+EXP_W+MAN_W
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand pair valid
- in_ready  output  1  block accepts operands this cycle
- in_a, in_b  input  W  operands {sign, exp, man}
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_result  output  W  product
- out_flags  output  4  {invalid, overflow, underflow, inexact}

## Operation
- Stage 1: unpack, classify (zero/normal/Inf/NaN), sign = a.s ^ b.s, exponent sum ea+eb-bias in EXP_W+2-bit signed arithmetic.
- Stage 2: unsigned multiply of {1,man} × {1,man}, product width 2*(MAN_W+1).
- Stage 3: normalise, round, pack, flag.
- Exp field 0 on input is zero; nonzero mantissa with exp 0 (subnormal) flushed to signed zero, no flag.
- Normalise: if product MSB set, take it as hidden bit and exponent +1; else shift left 1.
- Guard = first dropped bit; sticky = OR of remaining dropped bits; inexact = guard | sticky.
- Rounding per Configuration; a mantissa carry-out from rounding renormalises (mantissa 0, exponent +1).
- Final exponent ≥ 2^EXP_W-1 → {sign, all-ones, 0} (Inf), overflow=1, inexact=1.
- Final exponent ≤ 0 → {sign, 0}, underflow=1, inexact=1.
- Specials, checked before arithmetic, in this order:
  - either operand NaN, or Inf×0 → canonical qNaN {0, all-ones, 1, 0…0}, invalid=1.
  - Inf × nonzero → signed Inf, flags 0.
  - zero × finite → signed zero, flags 0.
- Flags are per-result and do not accumulate.

## Timing
- Advance enable en = !out_valid | out_ready; in_ready = en (combinational).
- Whole pipeline advances when en=1; a bubble enters when in_valid=0.
- Latency: 3 cycles from accepted input to out_valid with no stall. Throughput: 1 result/cycle.
- While out_valid=1 and out_ready=0:
  - all stages hold;
  - out_result and out_flags stay stable;
  - in_ready=0.
- Transfer happens when valid & ready on the same edge. Simultaneous output pop and input push is allowed at full rate.
- Reset, at any time including mid-stream, does the following:
  - clears all stage valids, discards in-flight operands;
  - out_valid=0, out_result=0, out_flags=0;
  - in_ready=1 after reset.
- No state machine beyond per-stage valid bits; data registers update only when en=1.

## Configuration
- FP_MUL_PIPE_RNE_EN defined: round-to-nearest-even. Increment mantissa when guard & (sticky | lsb).
- Not defined: truncation (round toward zero), no increment. Inexact is still reported. Overflow saturates to Inf in both modes.

## Test plan
All cases use the default parameters (fp16).
- Basic: 0x3E00 × 0x3E00 (1.5×1.5) → 0x4080, flags 0, out_valid exactly 3 cycles after accept.
- Overflow/underflow:
  - 0x7BFF × 0x4000 → 0x7C00, flags overflow|inexact.
  - 0x0400 × 0x3800 → 0x0000, flags underflow|inexact.
- Specials:
  - 0x7C00 × 0x0000 → 0x7E00, invalid.
  - 0xFC00 × 0x4000 → 0xFC00, flags 0.
  - 0x7E00 × 0x3C00 → 0x7E00, invalid.
- Rounding tie: 0x3C01 × 0x3E00 → 0x3E02 with FP_MUL_PIPE_RNE_EN, 0x3E01 without; inexact=1 in both.
- Backpressure: stream 8 back-to-back pairs, hold out_ready=0 for 5 cycles mid-stream.
  - Results arrive in order, none lost or duplicated.
  - Outputs stable during the stall.
  - in_ready=0 exactly while out_valid & !out_ready.
- Reset mid-stream: assert rst with 3 ops in flight.
  - out_valid drops immediately (async), out_result=0.
  - After release, the first new op emerges 3 cycles after accept, with no stale results.

Source files
------------

// File: rtl/fp_mul_pipe_if.sv
// fp_mul_pipe_if: operand/result stream bundle for fp_mul_pipe.
// The master drives operands and out_ready. The slave (the multiplier)
// drives in_ready and the result stream.
interface fp_mul_pipe_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;   // {invalid, overflow, underflow, inexact}

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: parameterised 3-stage pipelined floating-point multiplier.
//   Stage 1: unpack, classify, sign, biased exponent sum.
//   Stage 2: significand multiply.
//   Stage 3: normalise, round, pack, flags.
// A single advance enable moves the whole pipeline, so a stalled output
// holds every stage.
// Optional feature macro: FP_MUL_PIPE_RNE_EN selects round-to-nearest-even.
// When the macro is undefined, the result is truncated (rounded toward zero).
// Subnormal inputs are flushed to signed zero.
module fp_mul_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic         clk,
  input  logic         rst,
  fp_mul_pipe_if.slave bus
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = EXP_W + 2;          // signed exponent working width
  localparam int MW = MAN_W + 1;          // significand with hidden bit
  localparam int PW = 2 * MW;             // full product width

  localparam logic signed [SW-1:0] BIAS    = SW'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [SW-1:0] EXP_MAX = SW'(2 ** EXP_W - 1);
  localparam logic [EXP_W-1:0]     EXP_ONES = {EXP_W{1'b1}};
  localparam logic [W-1:0]         QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [3:0] F_INVALID   = 4'b1000;
  localparam logic [3:0] F_OVERFLOW  = 4'b0100;
  localparam logic [3:0] F_UNDERFLOW = 4'b0010;
  localparam logic [3:0] F_INEXACT   = 4'b0001;

  // ---------------------------------------------------------------------
  // Advance enable: the pipeline moves whenever the output slot is empty
  // or is being consumed this cycle.
  // ---------------------------------------------------------------------
  logic en;
  logic out_valid_q;

  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  // ---------------------------------------------------------------------
  // Stage 1 combinational: unpack and classify both operands
  // ---------------------------------------------------------------------
  logic               a_s, b_s;
  logic [EXP_W-1:0]   a_e, b_e;
  logic [MAN_W-1:0]   a_m, b_m;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               c1_sign;
  logic signed [SW-1:0] c1_exp;
  logic               c1_special;
  logic [W-1:0]       c1_sp_result;
  logic [3:0]         c1_sp_flags;

  assign {a_s, a_e, a_m} = bus.in_a;
  assign {b_s, b_e, b_m} = bus.in_b;

  // Exponent field 0 covers both true zero and flushed subnormals.
  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);
  assign a_inf  = (a_e == EXP_ONES) && (a_m == '0);
  assign b_inf  = (b_e == EXP_ONES) && (b_m == '0);
  assign a_nan  = (a_e == EXP_ONES) && (a_m != '0);
  assign b_nan  = (b_e == EXP_ONES) && (b_m != '0);

  assign c1_sign = a_s ^ b_s;
  assign c1_exp  = $signed({2'b00, a_e}) + $signed({2'b00, b_e}) - BIAS;

  // Resolve special operands up front; priority NaN/invalid, Inf, zero.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    c1_special   = 1'b0;
    c1_sp_result = '0;
    c1_sp_flags  = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      c1_special   = 1'b1;
      c1_sp_result = QNAN;
      c1_sp_flags  = F_INVALID;
    end else if (a_inf || b_inf) begin
      c1_special   = 1'b1;
      c1_sp_result = {c1_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      c1_special   = 1'b1;
      c1_sp_result = {c1_sign, {(W-1){1'b0}}};
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------
  logic                 s1_valid;
  logic                 s1_sign;
  logic signed [SW-1:0] s1_exp;
  logic [MW-1:0]        s1_ma, s1_mb;
  logic                 s1_special;
  logic [W-1:0]         s1_sp_result;
  logic [3:0]           s1_sp_flags;

  // Stage 1 valid bit: a bubble enters whenever in_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      s1_valid <= bus.in_valid;
    end
  end

  // Stage 1 payload capture.
  always_ff @(posedge clk) begin
    // NOTE: payload flops have no reset; they are only observed when the matching valid bit is set.
    if (en) begin
      s1_sign      <= c1_sign;
      s1_exp       <= c1_exp;
      s1_ma        <= {1'b1, a_m};
      s1_mb        <= {1'b1, b_m};
      s1_special   <= c1_special;
      s1_sp_result <= c1_sp_result;
      s1_sp_flags  <= c1_sp_flags;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2 registers: significand product
  // ---------------------------------------------------------------------
  logic                 s2_valid;
  logic                 s2_sign;
  logic signed [SW-1:0] s2_exp;
  logic [PW-1:0]        s2_prod;
  logic                 s2_special;
  logic [W-1:0]         s2_sp_result;
  logic [3:0]           s2_sp_flags;

  // Stage 2 valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
    end
  end

  // Stage 2 payload: multiply and forward the classification.
  always_ff @(posedge clk) begin
    if (en) begin
      s2_sign      <= s1_sign;
      s2_exp       <= s1_exp;
      s2_prod      <= s1_ma * s1_mb;
      s2_special   <= s1_special;
      s2_sp_result <= s1_sp_result;
      s2_sp_flags  <= s1_sp_flags;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3 combinational: normalise, round, pack
  // ---------------------------------------------------------------------
  logic [PW-2:0]        norm;       // product with the hidden bit dropped
  logic signed [SW-1:0] n_exp;
  logic [MAN_W-1:0]     n_man;
  logic                 guard;
  logic                 sticky;
  logic                 round_inc;
  logic [MAN_W:0]       man_rnd;
  logic [MAN_W-1:0]     f_man;
  logic signed [SW-1:0] f_exp;
  logic [W-1:0]         c3_result;
  logic [3:0]           c3_flags;

  // The product of two [1,2) significands lies in [1,4): at most one
  // position of normalisation is needed.
  assign norm  = s2_prod[PW-1] ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
  assign n_exp = s2_prod[PW-1] ? s2_exp + SW'(1) : s2_exp;

  assign n_man  = norm[PW-2 -: MAN_W];
  assign guard  = norm[PW-2-MAN_W];
  assign sticky = |norm[PW-3-MAN_W:0];

`ifdef FP_MUL_PIPE_RNE_EN
  assign round_inc = guard && (sticky || n_man[0]);
`else
  assign round_inc = 1'b0;
`endif

  assign man_rnd = {1'b0, n_man} + {{MAN_W{1'b0}}, round_inc};

  // A carry out of rounding gives exactly 2.0: the mantissa becomes 0 and the exponent is incremented.
  assign f_man = man_rnd[MAN_W] ? '0 : man_rnd[MAN_W-1:0];
  assign f_exp = man_rnd[MAN_W] ? n_exp + SW'(1) : n_exp;

  // Select the special result, saturate on overflow or underflow, or pack the normal result.
  always_comb begin
    c3_result = '0;
    c3_flags  = '0;
    if (s2_special) begin
      c3_result = s2_sp_result;
      c3_flags  = s2_sp_flags;
    end else if (f_exp >= EXP_MAX) begin
      c3_result = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      c3_flags  = F_OVERFLOW | F_INEXACT;
    end else if (f_exp <= 0) begin
      c3_result = {s2_sign, {(W-1){1'b0}}};
      c3_flags  = F_UNDERFLOW | F_INEXACT;
    end else begin
      c3_result = {s2_sign, f_exp[EXP_W-1:0], f_man};
      c3_flags  = (guard || sticky) ? F_INEXACT : 4'b0000;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3 / output registers
  // ---------------------------------------------------------------------
  logic [W-1:0] out_result_q;
  logic [3:0]   out_flags_q;

  // Output slot: cleared by reset and held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else if (en) begin
      out_valid_q  <= s2_valid;
      out_result_q <= c3_result;
      out_flags_q  <= c3_flags;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_flags  = out_flags_q;

endmodule
